word_serializer: RTL and testbench

//   Upstream feeder for the serial sequence-detector / ones-counter top: takes WIDTH-bit parallel words

---
 rtl/word_serializer_pkg.sv | 18 +
 rtl/word_serializer_if.sv | 21 ++
 rtl/word_serializer_popcount.sv | 18 +
 rtl/word_serializer.sv | 102 ++++++++++
 tb/tb_word_serializer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/word_serializer_pkg.sv
// Shared types and defaults for the word serializer.
// Parity framing is enabled by defining WORD_SER_PARITY_EN.
package word_ser_pkg;

  localparam int DEF_WIDTH = 10;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_SHIFT  = 2'(SHIFT);
  localparam logic [1:0] S_PARITY = 2'(PARITY);

endpackage

// File: rtl/word_serializer_if.sv
// Parallel word input handshake for the serializer.
// master = word source, slave = serializer.
interface word_serializer_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/word_serializer_popcount.sv
// Combinational ones count of a word.
// Result is unsigned and zero-extended to CNT_W.
module popcount #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 5
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial MSB-first shifter with per-word popcount.
// Define WORD_SER_PARITY_EN to append an even-parity bit to each frame.
module word_serializer
  import word_ser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  word_serializer_if.slave   in_if,
  output logic               ser_bit,
  output logic               ser_valid,
  output logic               ser_last,
  output logic [CNT_W-1:0]   ones_cnt,
  output logic               ones_valid,
  output logic               busy
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef WORD_SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [IW-1:0]    idx;
  logic             par;
  logic [CNT_W-1:0] pc;
  logic             accept;

  popcount #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_pop (
    .data (in_if.in_data),
    .cnt  (pc)
  );

  // ser_last is registered, so ready stays glitch-free
  assign in_if.in_ready = (state == S_IDLE) || ser_last;
  assign accept = in_if.in_valid && in_if.in_ready;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sreg       <= '0;
      idx        <= '0;
      par        <= 1'b0;
      ser_bit    <= 1'b0;
      ser_valid  <= 1'b0;
      ser_last   <= 1'b0;
      ones_cnt   <= '0;
      ones_valid <= 1'b0;
    end else begin
      ones_valid <= 1'b0;
      if (accept) begin
        state      <= S_SHIFT;
        ser_bit    <= in_if.in_data[WIDTH-1];
        sreg       <= {in_if.in_data[WIDTH-2:0], 1'b0};
        idx        <= IW'(WIDTH - 1);
        par        <= ^in_if.in_data;
        ser_valid  <= 1'b1;
        ser_last   <= 1'b0;
        ones_cnt   <= pc;
        ones_valid <= 1'b1;
      end else begin
        case (state)
          S_SHIFT: begin
            if (idx != '0) begin
              idx      <= idx - IW'(1);
              ser_bit  <= sreg[WIDTH-1];
              sreg     <= {sreg[WIDTH-2:0], 1'b0};
              ser_last <= !PAR_EN && (idx == IW'(1));
            end else if (PAR_EN) begin
              state    <= S_PARITY;
              ser_bit  <= par;
              ser_last <= 1'b1;
            end else begin
              state     <= S_IDLE;
              ser_bit   <= 1'b0;
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
            end
          end
          default: begin
            state     <= S_IDLE;
            idx       <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer against a frame-queue model.
// Honors WORD_SER_PARITY_EN to model the parity bit.
module tb_word_serializer;
  import word_ser_pkg::*;

  localparam int W = 10;
  localparam int CW = 5;

`ifdef WORD_SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic b;
    logic last;
    logic first;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  logic ser_bit, ser_valid, ser_last, ones_valid, busy;
  logic [CW-1:0] ones_cnt;

  word_serializer_if #(.WIDTH(W)) bus ();

  word_serializer #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (bus.slave),
    .ser_bit    (ser_bit),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .ones_cnt   (ones_cnt),
    .ones_valid (ones_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  item_t   q[$];
  item_t   cur;
  bit      cur_v = 1'b0;
  bit      known = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_ready();
    return !cur_v || cur.last;
  endfunction

  task automatic step(input logic v, input logic [W-1:0] d,
                      input logic r, output bit acc);
    item_t it;
    bus.in_valid = v;
    bus.in_data  = d;
    rst = r;
    if (known) chk("in_ready", {31'b0, bus.in_ready}, {31'b0, m_ready()});
    acc = v && !r && known && m_ready();
    @(posedge clk);
    if (r) begin
      q.delete();
      cur_v = 1'b0;
      m_cnt = '0;
      known = 1'b1;
    end else begin
      if (acc) begin
        q.delete();
        for (int i = W - 1; i >= 0; i--) begin
          it.b = d[i];
          it.last = (i == 0) && !PAR;
          it.first = (i == W - 1);
          q.push_back(it);
        end
        if (PAR) begin
          it.b = ^d;
          it.last = 1'b1;
          it.first = 1'b0;
          q.push_back(it);
        end
        m_cnt = CW'($countones(d));
      end
      if (q.size() > 0) begin
        cur = q.pop_front();
        cur_v = 1'b1;
      end else begin
        cur_v = 1'b0;
      end
    end
    #1;
    chk("ser_valid", {31'b0, ser_valid}, {31'b0, cur_v});
    chk("ser_bit", {31'b0, ser_bit}, {31'b0, cur_v && cur.b});
    chk("ser_last", {31'b0, ser_last}, {31'b0, cur_v && cur.last});
    chk("ones_valid", {31'b0, ones_valid}, {31'b0, cur_v && cur.first});
    chk("ones_cnt", {27'b0, ones_cnt}, {27'b0, m_cnt});
    chk("busy", {31'b0, busy}, {31'b0, cur_v});
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, a);
  endtask

  task automatic send(input logic [W-1:0] d);
    bit a;
    int n;
    a = 1'b0;
    n = 0;
    while (!a && n < 40) begin
      step(1'b1, d, 1'b0, a);
      n++;
    end
    checks++;
    if (!a) begin
      errors++;
      $error("FAIL send_timeout got 0 exp 1");
    end
  endtask

  initial begin
    bit a;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;

    // reset, with a word offered during reset that must be dropped
    step(1'b0, '0, 1'b1, a);
    step(1'b1, 10'b1111111111, 1'b1, a);
    idle(2);

    send(10'b1010101010);
    idle(W + 3);

    // back-to-back with valid held; second accept on ser_last cycle
    send(10'b1100110011);
    send(10'b0010101010);
    checks++;
    assert (ser_valid === 1'b1 && ones_valid === 1'b1 && ones_cnt === 5'd4)
    else begin
      errors++;
      $error("FAIL b2b_second got %b%b%0d exp 114", ser_valid, ones_valid, ones_cnt);
    end
    idle(W + 3);

    // valid pulsed mid-word is ignored
    send(10'b1010101010);
    idle(3);
    step(1'b1, 10'b1111111111, 1'b0, a);
    idle(W);

    // reset on 4th bit aborts the frame
    send(10'b1010101011);
    idle(3);
    step(1'b0, '0, 1'b1, a);
    idle(3);

    send(10'b1010101011);
    idle(W + 3);
    send(10'b0000000001);
    idle(W + 3);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 2) != 0), W'($urandom),
           1'($urandom_range(0, 60) == 0), a);
    end
    idle(W + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
